bram_dp_be: RTL and testbench

- Single-clock, true dual-port block RAM; successor to the dual-clock byte-wide bram.
- Adds parametrised data and address widths, per-byte write enables, and a request/read-valid handshake per port.
- Adds configurable read latency (1 or 2) and a defined cross-port collision mode.
- Sits between the core's fetch/load-store units and on-chip memory; port A is the load/store side, port B the fetch/DMA side.

---
 rtl/bram_dp_be.sv | 93 +++++++++
 tb/tb_bram_dp_be.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bram_dp_be.sv
// bram_dp_be: single-clock true dual-port RAM with byte enables, read-valid handshake,
//   selectable read latency (1 or 2) and selectable cross-port collision behaviour.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_x, i_write_x             request valid, 1 = write / 0 = read
//   i_be_x, i_addr_x, i_data_x     byte enables, word address, write data
//   o_data_x, o_rvalid_x           read data (held between reads), one-cycle valid pulse
//   x = a (load/store side, wins byte conflicts) or b (fetch/DMA side)
module bram_dp_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int READ_LATENCY   = 1,
   parameter int COLLISION_MODE = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_a,
   input  logic                    i_write_a,
   input  logic [DATA_WIDTH/8-1:0] i_be_a,
   input  logic [ADDR_WIDTH-1:0]   i_addr_a,
   input  logic [DATA_WIDTH-1:0]   i_data_a,
   output logic [DATA_WIDTH-1:0]   o_data_a,
   output logic                    o_rvalid_a,
   input  logic                    i_req_b,
   input  logic                    i_write_b,
   input  logic [DATA_WIDTH/8-1:0] i_be_b,
   input  logic [ADDR_WIDTH-1:0]   i_addr_b,
   input  logic [DATA_WIDTH-1:0]   i_data_b,
   output logic [DATA_WIDTH-1:0]   o_data_b,
   output logic                    o_rvalid_b
);
   localparam int NB = DATA_WIDTH / 8;
   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
   logic                  wr_a, wr_b, same_addr;
   logic [1:0]            rd, v1_q, rv_q, val_d;
   logic [DATA_WIDTH-1:0] rdata [2];
   logic [DATA_WIDTH-1:0] d1_q [2];
   logic [DATA_WIDTH-1:0] do_q [2];
   logic [DATA_WIDTH-1:0] dat_d [2];
   assign wr_a      = i_req_a & i_write_a;
   assign wr_b      = i_req_b & i_write_b;
   assign same_addr = i_addr_a == i_addr_b;
   assign rd        = {i_req_b & ~i_write_b, i_req_a & ~i_write_a};
   // B's byte is suppressed where A writes the same byte of the same word, so A wins.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < NB; k++) begin
         if (wr_a && i_be_a[k])
            mem[i_addr_a][8*k +: 8] <= i_data_a[8*k +: 8];
         if (wr_b && i_be_b[k] && !(wr_a && i_be_a[k] && same_addr))
            mem[i_addr_b][8*k +: 8] <= i_data_b[8*k +: 8];
      end
   end
   // WRITE_FIRST bypass: a reader sees the other port's enabled bytes from this same edge.
   always_comb begin
      rdata[0] = mem[i_addr_a];
      rdata[1] = mem[i_addr_b];
      for (int k = 0; k < NB; k++) begin
         if (COLLISION_MODE == 1 && same_addr && wr_b && i_be_b[k])
            rdata[0][8*k +: 8] = i_data_b[8*k +: 8];
         if (COLLISION_MODE == 1 && same_addr && wr_a && i_be_a[k])
            rdata[1][8*k +: 8] = i_data_a[8*k +: 8];
      end
   end
   // Output register is fed directly (latency 1) or through one extra stage (latency 2).
   always_comb begin
      val_d = READ_LATENCY == 2 ? v1_q : rd;
      for (int p = 0; p < 2; p++)
         dat_d[p] = READ_LATENCY == 2 ? d1_q[p] : rdata[p];
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v1_q <= '0;
         rv_q <= '0;
         for (int p = 0; p < 2; p++) begin
            d1_q[p] <= '0;
            do_q[p] <= '0;
         end
      end else begin
         v1_q <= rd;
         rv_q <= val_d;
         for (int p = 0; p < 2; p++) begin
            if (rd[p])
               d1_q[p] <= rdata[p];
            if (val_d[p])
               do_q[p] <= dat_d[p];
         end
      end
   end
   assign o_data_a   = do_q[0];
   assign o_data_b   = do_q[1];
   assign o_rvalid_a = rv_q[0];
   assign o_rvalid_b = rv_q[1];
endmodule

// File: tb/tb_bram_dp_be.sv
// tb_bram_dp_be: two DUT instances (latency 1 / READ_FIRST and latency 2 / WRITE_FIRST) on shared inputs
module tb_bram_dp_be;
   logic        clk = 0, rst_n = 0;
   logic        req_a = 0, write_a = 0, req_b = 0, write_b = 0;
   logic [3:0]  be_a = 0, be_b = 0;
   logic [11:0] addr_a = 0, addr_b = 0;
   logic [31:0] data_a = 0, data_b = 0;
   logic [31:0] od [4];
   logic [3:0]  ov;
   int          tests = 0, fails = 0, cyc = 0;
   typedef struct {int due; logic [31:0] d;} pend_t;
   pend_t       pq [4][$];
   logic [31:0] hd [4];
   logic [31:0] m [int];
   typedef struct {
      logic ra, wa; logic [3:0] bea; logic [11:0] aa; logic [31:0] da;
      logic rb, wb; logic [3:0] beb; logic [11:0] ab; logic [31:0] db;
      logic ca, cb; logic [31:0] ea0, ea1, eb0, eb1;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   bram_dp_be #(.READ_LATENCY(1), .COLLISION_MODE(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_a(req_a), .i_write_a(write_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_data_a(data_a),
      .o_data_a(od[0]), .o_rvalid_a(ov[0]),
      .i_req_b(req_b), .i_write_b(write_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_data_b(data_b),
      .o_data_b(od[1]), .o_rvalid_b(ov[1]));
   bram_dp_be #(.READ_LATENCY(2), .COLLISION_MODE(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_a(req_a), .i_write_a(write_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_data_a(data_a),
      .o_data_a(od[2]), .o_rvalid_a(ov[2]),
      .i_req_b(req_b), .i_write_b(write_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_data_b(data_b),
      .o_data_b(od[3]), .o_rvalid_b(ov[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [11:0] a);
      return m.exists(int'(a)) ? m[int'(a)] : 32'h0;
   endfunction

   // Value a read on port p returns this edge, given the instance's collision mode.
   function automatic logic [31:0] rd_val(input int p, input int mode);
      logic [11:0] a   = p ? addr_b : addr_a;
      logic [11:0] oa  = p ? addr_a : addr_b;
      logic        ow  = p ? (req_a && write_a) : (req_b && write_b);
      logic [3:0]  obe = p ? be_a : be_b;
      logic [31:0] odt = p ? data_a : data_b;
      logic [31:0] v   = rd_mem(a);
      if (mode == 1 && ow && oa == a)
         for (int b = 0; b < 4; b++)
            if (obe[b]) v[8*b +: 8] = odt[8*b +: 8];
      return v;
   endfunction

   task automatic wr_model(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] v = rd_mem(a);
      for (int b = 0; b < 4; b++)
         if (be[b]) v[8*b +: 8] = d[8*b +: 8];
      m[int'(a)] = v;
   endtask

   task automatic model_edge();
      for (int k = 0; k < 4; k++) begin
         logic rq = (k % 2) ? (req_b && !write_b) : (req_a && !write_a);
         if (rq) pq[k].push_back('{cyc + (k < 2 ? 1 : 2) - 1, rd_val(k % 2, k < 2 ? 0 : 1)});
      end
      // B first, then A on top: A wins any byte both ports enable.
      if (req_b && write_b) wr_model(addr_b, be_b, data_b);
      if (req_a && write_a) wr_model(addr_a, be_a, data_a);
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 4; k++) begin
         logic due = pq[k].size() > 0 && pq[k][0].due == cyc;
         if (due) hd[k] = pq[k].pop_front().d;
         chk($sformatf("rvalid[%0d]", k), 32'(ov[k]), 32'(due));
         chk($sformatf("data[%0d]", k), od[k], hd[k]);
      end
   endtask

   task automatic cycle(input logic ra, wa, input logic [3:0] bea, input logic [11:0] aa, input logic [31:0] da,
                        input logic rb, wb, input logic [3:0] beb, input logic [11:0] ab, input logic [31:0] db);
      req_a = ra; write_a = wa; be_a = bea; addr_a = aa; data_a = da;
      req_b = rb; write_b = wb; be_b = beb; addr_b = ab; data_b = db;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_zero(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_rvalid"}, 32'(ov[k]), 32'h0);
         chk({tag, "_data"}, od[k], 32'h0);
      end
   endtask

   initial begin
      int pulses;
      tbl[0]  = '{1,1,4'hF,12'h000,32'hAABBCCDD, 0,0,4'h0,12'h000,32'h0, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[1]  = '{1,1,4'h5,12'h000,32'h11223344, 0,0,4'h0,12'h000,32'h0, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[2]  = '{1,0,4'h0,12'h000,32'h0,        0,0,4'h0,12'h000,32'h0, 1,0, 32'hAA22CC44,32'hAA22CC44,32'h0,32'h0};
      tbl[3]  = '{1,1,4'hF,12'h005,32'h00000001, 0,0,4'h0,12'h000,32'h0, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[4]  = '{1,1,4'hF,12'h005,32'hFFFFFFFF, 1,0,4'h0,12'h005,32'h0, 0,1, 32'h0,32'h0,32'h00000001,32'hFFFFFFFF};
      tbl[5]  = '{0,0,4'h0,12'h000,32'h0,        1,0,4'h0,12'h005,32'h0, 0,1, 32'h0,32'h0,32'hFFFFFFFF,32'hFFFFFFFF};
      tbl[6]  = '{1,1,4'hF,12'h007,32'h0,        0,0,4'h0,12'h000,32'h0, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[7]  = '{1,1,4'h3,12'h007,32'h11111111, 1,1,4'h6,12'h007,32'h22222222, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[8]  = '{1,0,4'h0,12'h007,32'h0,        0,0,4'h0,12'h000,32'h0, 1,0, 32'h00221111,32'h00221111,32'h0,32'h0};
      tbl[9]  = '{1,1,4'hF,12'hFFF,32'hDEADBEEF, 1,1,4'hF,12'h000,32'hCAFEF00D, 0,0, 32'h0,32'h0,32'h0,32'h0};
      tbl[10] = '{1,0,4'h0,12'h000,32'h0,        1,0,4'h0,12'hFFF,32'h0, 1,1, 32'hCAFEF00D,32'hCAFEF00D,32'hDEADBEEF,32'hDEADBEEF};
      for (int k = 0; k < 4; k++) hd[k] = 0;
      repeat (2) @(posedge clk);
      #1 check_reset_zero("reset");
      @(negedge clk) rst_n = 1;
      // Directed vectors, each drained so the held output shows that vector's read result.
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].ra, tbl[i].wa, tbl[i].bea, tbl[i].aa, tbl[i].da,
               tbl[i].rb, tbl[i].wb, tbl[i].beb, tbl[i].ab, tbl[i].db);
         idle(2);
         if (tbl[i].ca) begin
            chk($sformatf("vec%0d_a_lat1", i), od[0], tbl[i].ea0);
            chk($sformatf("vec%0d_a_lat2", i), od[2], tbl[i].ea1);
         end
         if (tbl[i].cb) begin
            chk($sformatf("vec%0d_b_rdfirst", i), od[1], tbl[i].eb0);
            chk($sformatf("vec%0d_b_wrfirst", i), od[3], tbl[i].eb1);
         end
      end
      // Pipelined back-to-back reads.
      for (int i = 0; i < 16; i++) cycle(1, 1, 4'hF, 12'(i), 32'h100 + i, 0, 0, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0, 0, 0, 1, 0, 0, 12'(i), 0);
         pulses += int'(ov[3]);
      end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         pulses += int'(ov[3]);
      end
      chk("pipe_pulses", 32'(pulses), 32'd8);
      chk("pipe_hold_lat2", od[3], 32'h107);
      chk("pipe_hold_lat1", od[1], 32'h107);
      // Reset while a read is in flight.
      cycle(1, 0, 0, 12'hFFF, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 0;
      #1 check_reset_zero("midreset");
      for (int k = 0; k < 4; k++) begin
         pq[k].delete();
         hd[k] = 0;
      end
      @(negedge clk) rst_n = 1;
      idle(3);
      cycle(1, 0, 0, 12'hFFF, 0, 0, 0, 0, 0, 0);
      idle(2);
      chk("post_reset_lat1", od[0], 32'hDEADBEEF);
      chk("post_reset_lat2", od[2], 32'hDEADBEEF);
      // Random traffic on a small address window so collisions are common.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom), 1'($urandom), 4'($urandom), 12'($urandom_range(15)), $urandom,
               1'($urandom), 1'($urandom), 4'($urandom), 12'($urandom_range(15)), $urandom);
      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
